data_cache_ctrl: RTL and testbench



---
 rtl/data_cache_ctrl_if.sv | 36 +++
 rtl/data_cache_ctrl.sv | 117 +++++++++++
 tb/tb_data_cache_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_cache_ctrl_if.sv
// Bus bundle for data_cache_ctrl: CPU load/store side and block memory side.
// Names carry the cache's point of view: i_* flow into the cache, o_* out of it.
//   CPU side : i_read, i_write, i_address[7:0], i_writedata[7:0],
//              o_readdata[7:0], o_busywait
//   Mem side : i_mem_readdata[31:0], i_mem_busywait,
//              o_mem_read, o_mem_write, o_mem_address[5:0], o_mem_writedata[31:0]
interface data_cache_ctrl_if;
    logic        i_read;
    logic        i_write;
    logic [7:0]  i_address;
    logic [7:0]  i_writedata;
    logic [7:0]  o_readdata;
    logic        o_busywait;
    logic [31:0] i_mem_readdata;
    logic        i_mem_busywait;
    logic        o_mem_read;
    logic        o_mem_write;
    logic [5:0]  o_mem_address;
    logic [31:0] o_mem_writedata;

    // Cache side
    modport slave (
        input  i_read, i_write, i_address, i_writedata,
        input  i_mem_readdata, i_mem_busywait,
        output o_readdata, o_busywait,
        output o_mem_read, o_mem_write, o_mem_address, o_mem_writedata
    );

    // CPU + memory environment side
    modport master (
        output i_read, i_write, i_address, i_writedata,
        output i_mem_readdata, i_mem_busywait,
        input  o_readdata, o_busywait,
        input  o_mem_read, o_mem_write, o_mem_address, o_mem_writedata
    );
endinterface

// File: rtl/data_cache_ctrl.sv
// Direct-mapped write-back data cache: 8 lines x 4 bytes, 3-bit tag/index,
// 2-bit offset. Hits complete with no stall; misses stall via o_busywait,
// write back a dirty victim, then refill the block from memory.
// Ports:
//   i_clk - clock, all state updates on posedge
//   i_rst - asynchronous active-high reset
//   bus   - data_cache_ctrl_if.slave (CPU request/response + block memory)
module data_cache_ctrl (
    input  logic             i_clk,
    input  logic             i_rst,
    data_cache_ctrl_if.slave bus
);
    localparam int unsigned LINES = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2,
        UPDATE    = 2'd3
    } state_t;

    state_t          r_state;
    logic [LINES-1:0] r_valid;
    logic [LINES-1:0] r_dirty;
    logic [2:0]      r_tag  [LINES];
    logic [31:0]     r_data [LINES];
    logic            r_mem_read;
    logic            r_mem_write;

    logic [2:0]  w_tag;
    logic [2:0]  w_index;
    logic [1:0]  w_offset;
    logic        w_req;
    logic        w_hit;
    logic [31:0] w_line;
    logic [31:0] w_merged;
    logic [7:0]  w_byte;

    assign w_tag    = bus.i_address[7:5];
    assign w_index  = bus.i_address[4:2];
    assign w_offset = bus.i_address[1:0];
    assign w_req    = bus.i_read | bus.i_write;
    assign w_hit    = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_line   = r_data[w_index];
    assign w_byte   = w_line[{w_offset, 3'b000} +: 8];

    // Current line with the store byte merged in at the addressed offset
    always_comb begin
        w_merged = w_line;
        w_merged[{w_offset, 3'b000} +: 8] = bus.i_writedata;
    end

    // Miss sequencing plus valid/dirty bookkeeping
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_valid     <= '0;
            r_dirty     <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_req && !w_hit) begin
                        if (r_valid[w_index] && r_dirty[w_index]) begin
                            r_state     <= WRITEBACK;
                            r_mem_write <= 1'b1;
                        end else begin
                            r_state    <= FETCH;
                            r_mem_read <= 1'b1;
                        end
                    end else if (w_req && bus.i_write) begin
                        r_dirty[w_index] <= 1'b1;
                    end
                end
                WRITEBACK: begin
                    if (!bus.i_mem_busywait) begin
                        r_state     <= FETCH;
                        r_mem_write <= 1'b0;
                        r_mem_read  <= 1'b1;
                    end
                end
                FETCH: begin
                    if (!bus.i_mem_busywait) begin
                        r_state    <= UPDATE;
                        r_mem_read <= 1'b0;
                    end
                end
                UPDATE: begin
                    r_valid[w_index] <= 1'b1;
                    r_dirty[w_index] <= 1'b0;
                    r_state          <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Line storage; a refill written while reset is pending stays invalid
    always_ff @(posedge i_clk) begin
        if (r_state == UPDATE) begin
            r_data[w_index] <= bus.i_mem_readdata;
            r_tag[w_index]  <= w_tag;
        end else if (r_state == IDLE && w_req && w_hit && bus.i_write) begin
            r_data[w_index] <= w_merged;
        end
    end

    // Stall, hit data and memory address are combinational so hits cost no cycle
    assign bus.o_busywait      = (r_state != IDLE) || (w_req && !w_hit);
    assign bus.o_readdata      = w_hit ? w_byte : 8'h00;
    assign bus.o_mem_read      = r_mem_read;
    assign bus.o_mem_write     = r_mem_write;
    assign bus.o_mem_address   = (r_state == WRITEBACK) ? {r_tag[w_index], w_index}
                                                        : bus.i_address[7:2];
    assign bus.o_mem_writedata = w_line;
endmodule

// File: tb/tb_data_cache_ctrl.sv
// Scoreboard bench for data_cache_ctrl: directed accesses push expected CPU
// completions and memory transactions; negedge monitors pop and compare.
module tb_data_cache_ctrl;
    localparam int unsigned LAT = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_cache_ctrl_if bus ();

    data_cache_ctrl dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       is_rd;
        logic [7:0] data;
        int         stalls;
        string      name;
    } cpu_exp_t;

    typedef struct {
        logic        is_wr;
        logic [5:0]  addr;
        logic [31:0] data;
        string       name;
    } mem_exp_t;

    cpu_exp_t cpu_q[$];
    mem_exp_t mem_q[$];

    // Memory model: busy for LAT cycles after a request rises, then one free cycle
    logic [31:0] mem [64];
    int unsigned cnt;
    logic        mreq;
    assign mreq               = bus.o_mem_read | bus.o_mem_write;
    assign bus.i_mem_busywait = mreq && (cnt != LAT);
    assign bus.i_mem_readdata = mem[bus.o_mem_address];

    always @(posedge clk or posedge rst) begin
        if (rst) cnt <= 0;
        else if (mreq && cnt != LAT) cnt <= cnt + 1;
        else cnt <= 0;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[6'h01] <= 32'h44332211;
            mem[6'h09] <= 32'h88776655;
            mem[6'h11] <= 32'h12345678;
            mem[6'h20] <= 32'hDDCCBBAA;
            mem[6'h28] <= 32'h0F0E0D0C;
        end else if (bus.o_mem_write && cnt == LAT) begin
            mem[bus.o_mem_address] <= bus.o_mem_writedata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: CPU completions and memory request starts
    int   stalls  = 0;
    logic prev_rd = 1'b0;
    logic prev_wr = 1'b0;
    always @(negedge clk) begin
        cpu_exp_t ce;
        mem_exp_t me;
        if (rst) begin
            stalls  = 0;
            prev_rd = 1'b0;
            prev_wr = 1'b0;
        end else begin
            check("mem_rd_wr_exclusive", 32'(bus.o_mem_read & bus.o_mem_write), 32'h0);
            if (bus.i_read | bus.i_write) begin
                if (bus.o_busywait) begin
                    stalls++;
                end else begin
                    if (cpu_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_cpu_completion: got addr %0h expected none", bus.i_address);
                    end else begin
                        ce = cpu_q.pop_front();
                        if (ce.is_rd) check({ce.name, "_rdata"}, 32'(bus.o_readdata), 32'(ce.data));
                        check({ce.name, "_stalls"}, stalls, ce.stalls);
                    end
                    stalls = 0;
                end
            end
            if ((bus.o_mem_read && !prev_rd) || (bus.o_mem_write && !prev_wr)) begin
                if (mem_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_mem_req: got addr %0h expected none", bus.o_mem_address);
                end else begin
                    me = mem_q.pop_front();
                    check({me.name, "_kind"}, 32'(bus.o_mem_write), 32'(me.is_wr));
                    check({me.name, "_addr"}, 32'(bus.o_mem_address), 32'(me.addr));
                    if (me.is_wr) check({me.name, "_wdata"}, bus.o_mem_writedata, me.data);
                end
            end
            prev_rd = bus.o_mem_read;
            prev_wr = bus.o_mem_write;
        end
    end

    task automatic access(input logic rd, input logic wr, input logic [7:0] addr,
                          input logic [7:0] wdata, input logic [7:0] exp_rd,
                          input int exp_stalls, input string name);
        int n;
        cpu_q.push_back(cpu_exp_t'{rd && !wr, exp_rd, exp_stalls, name});
        bus.i_read      = rd;
        bus.i_write     = wr;
        bus.i_address   = addr;
        bus.i_writedata = wdata;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.o_busywait && n < 50);
        if (bus.o_busywait) begin
            total++; bad++;
            $display("FAIL %s_timeout: got busywait 1 expected 0 within 50 cycles", name);
        end
        @(posedge clk); #1;
        bus.i_read  = 1'b0;
        bus.i_write = 1'b0;
    endtask

    task automatic push_mem(input logic is_wr, input logic [5:0] addr,
                            input logic [31:0] data, input string name);
        mem_q.push_back(mem_exp_t'{is_wr, addr, data, name});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst             = 1'b1;
        bus.i_read      = 1'b0;
        bus.i_write     = 1'b0;
        bus.i_address   = 8'h00;
        bus.i_writedata = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busywait",  32'(bus.o_busywait),  32'h0);
        check("rst_mem_read",  32'(bus.o_mem_read),  32'h0);
        check("rst_mem_write", 32'(bus.o_mem_write), 32'h0);
        check("rst_readdata",  32'(bus.o_readdata),  32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Clean miss, then hits on the refilled line
        push_mem(1'b0, 6'h01, 32'h0, "fetch_05");
        access(1'b1, 1'b0, 8'h05, 8'h00, 8'h22, 6, "rd_05");
        access(1'b0, 1'b1, 8'h06, 8'hAB, 8'h00, 0, "wr_06");
        access(1'b1, 1'b0, 8'h06, 8'h00, 8'hAB, 0, "rd_06");

        // Dirty miss on index 1: writeback then refill
        push_mem(1'b1, 6'h01, 32'h44AB2211, "wb_line1");
        push_mem(1'b0, 6'h09, 32'h0, "fetch_25");
        access(1'b1, 1'b0, 8'h25, 8'h00, 8'h66, 10, "rd_25");

        // Write miss on clean invalid line: fetch only, byte merged, line dirty
        push_mem(1'b0, 6'h20, 32'h0, "fetch_80");
        access(1'b0, 1'b1, 8'h80, 8'h5A, 8'h00, 6, "wr_80");
        access(1'b1, 1'b0, 8'h80, 8'h00, 8'h5A, 0, "rd_80");
        push_mem(1'b1, 6'h20, 32'hDDCCBB5A, "wb_line0");
        push_mem(1'b0, 6'h28, 32'h0, "fetch_a0");
        access(1'b1, 1'b0, 8'hA0, 8'h00, 8'h0C, 10, "rd_a0");

        // READ and WRITE together act as a write
        access(1'b1, 1'b1, 8'hA1, 8'h77, 8'h00, 0, "rdwr_a1");
        access(1'b1, 1'b0, 8'hA1, 8'h00, 8'h77, 0, "rd_a1");

        // Reset in the middle of a refill
        push_mem(1'b0, 6'h11, 32'h0, "fetch_45_abort");
        bus.i_read    = 1'b1;
        bus.i_address = 8'h45;
        n = 0;
        while (!bus.o_mem_read && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("abort_fetch_started", 32'(bus.o_mem_read), 32'h1);
        @(posedge clk); #1;
        rst        = 1'b1;
        bus.i_read = 1'b0;
        #1;
        check("abort_mem_read",  32'(bus.o_mem_read),  32'h0);
        check("abort_mem_write", 32'(bus.o_mem_write), 32'h0);
        check("abort_busywait",  32'(bus.o_busywait),  32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        push_mem(1'b0, 6'h11, 32'h0, "fetch_45");
        access(1'b1, 1'b0, 8'h45, 8'h00, 8'h56, 6, "rd_45_after_rst");
        push_mem(1'b0, 6'h28, 32'h0, "fetch_a1_after_rst");
        access(1'b1, 1'b0, 8'hA1, 8'h00, 8'h0D, 6, "rd_a1_after_rst");

        // Idle: nothing moves
        repeat (10) begin
            @(negedge clk);
            check("idle_busywait",  32'(bus.o_busywait),  32'h0);
            check("idle_mem_read",  32'(bus.o_mem_read),  32'h0);
            check("idle_mem_write", 32'(bus.o_mem_write), 32'h0);
        end

        check("cpu_q_empty", cpu_q.size(), 32'h0);
        check("mem_q_empty", mem_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
